// File: rtl/led_bus_pkg.sv
// Shared constants for the bus-mapped LED controller: register bit positions,
// register offsets within the bus window, and blink limit arithmetic.
package led_bus_pkg;

  localparam int CTRL_BLINK_BIT   = 0;
  localparam int CTRL_INVERT_BIT  = 1;
  localparam int CTRL_RATE_LSB    = 4;
  localparam int STATUS_PHASE_BIT = 0;

  // Bits [3:2] of CTRL are reserved and always read back as zero.
  localparam logic [7:0] CTRL_WRITE_MASK = 8'hF3;
  localparam logic [7:0] BRIGHT_RESET    = 8'hFF;

  localparam int BLINK_CNT_W = 10;

  function automatic int ctrl_off(input int num_bytes);
    return num_bytes;
  endfunction

  function automatic int status_off(input int num_bytes);
    return num_bytes + 1;
  endfunction

  function automatic int bright_off(input int num_bytes);
    return num_bytes + 2;
  endfunction

  // Last blink count of a half period: (rate+1)*64-1 == {rate, 6'b111111}.
  function automatic logic [BLINK_CNT_W-1:0] blink_limit(input logic [3:0] rate);
    return {rate, 6'h3F};
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink time base: free-running prescaler producing a tick every PRESCALE clocks,
// and a tick counter that toggles the blink phase every (rate+1)*64 ticks.
module led_blink_timer
  import led_bus_pkg::*;
#(
  parameter int PRESCALE = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       restart,
  input  logic [3:0] rate,
  output logic       phase
);

  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0]        ps_cnt;
  logic                   tick;
  logic [BLINK_CNT_W-1:0] blink_cnt;
  logic [BLINK_CNT_W-1:0] limit;

  assign tick  = (ps_cnt == PS_W'(PRESCALE - 1));
  assign limit = blink_limit(rate);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // A rate lowered below the current count wraps on the very next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (restart || !enable) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (tick) begin
      if (blink_cnt >= limit) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_bus_interface_ctrl.sv
// Bus-mapped LED controller: DATA bytes, CTRL, STATUS (and BRIGHT when LED_PWM_EN
// is defined) on an 8-bit CPU bus with registered readback and blink/invert/PWM output.
module led_bus_interface_ctrl
  import led_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC0,
  parameter int         NUM_BYTES = 2,
  parameter int         PRESCALE  = 100000
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  inout  wire  [7:0]             BUS_DATA,
  input  logic [7:0]             BUS_ADDR,
  input  logic                   BUS_WE,
  output logic [8*NUM_BYTES-1:0] LEDS
);

  localparam int CTRL_OFF   = ctrl_off(NUM_BYTES);
  localparam int STATUS_OFF = status_off(NUM_BYTES);
`ifdef LED_PWM_EN
  localparam int BRIGHT_OFF = bright_off(NUM_BYTES);
  localparam int WIN        = NUM_BYTES + 3;
`else
  localparam int WIN        = NUM_BYTES + 2;
`endif

  logic [7:0] off;
  logic       hit;
  logic       wr;
  logic       rd;

  logic [7:0] data_q [NUM_BYTES];
  logic [7:0] ctrl_q;
  logic       blink_en;
  logic       invert;
  logic       phase;
  logic       restart;

  logic [7:0] rd_mux;
  logic [7:0] out_q;
  logic       drive_en;

  logic [8*NUM_BYTES-1:0] raw;
  logic [8*NUM_BYTES-1:0] gated;
  logic [8*NUM_BYTES-1:0] lit;

  // Compare in 9 bits so a window near 8'hFF never wraps back to 8'h00.
  assign off = BUS_ADDR - BASE_ADDR;
  assign hit = ({1'b0, BUS_ADDR} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, BUS_ADDR} <  ({1'b0, BASE_ADDR} + 9'(WIN)));
  assign wr  = hit && BUS_WE;
  assign rd  = hit && !BUS_WE;

  assign blink_en = ctrl_q[CTRL_BLINK_BIT];
  assign invert   = ctrl_q[CTRL_INVERT_BIT];
  assign restart  = wr && (off == 8'(CTRL_OFF)) && BUS_DATA[CTRL_BLINK_BIT] && !blink_en;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_BYTES; i++) data_q[i] <= '0;
      ctrl_q <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (off == 8'(i)) data_q[i] <= BUS_DATA;
      end
      if (off == 8'(CTRL_OFF)) ctrl_q <= BUS_DATA & CTRL_WRITE_MASK;
    end
  end

  led_blink_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .enable (blink_en),
    .restart(restart),
    .rate   (ctrl_q[CTRL_RATE_LSB +: 4]),
    .phase  (phase)
  );

`ifdef LED_PWM_EN
  logic [7:0] bright_q;
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bright_q <= BRIGHT_RESET;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (wr && (off == 8'(BRIGHT_OFF))) bright_q <= BUS_DATA;
    end
  end

  assign pwm_on = (pwm_cnt < bright_q) || (bright_q == 8'hFF);
  assign lit    = pwm_on ? gated : '0;
`else
  assign lit = gated;
`endif

  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (off == 8'(i)) rd_mux = data_q[i];
    end
    if (off == 8'(CTRL_OFF)) rd_mux = ctrl_q;
    if (off == 8'(STATUS_OFF)) rd_mux[STATUS_PHASE_BIT] = phase;
`ifdef LED_PWM_EN
    if (off == 8'(BRIGHT_OFF)) rd_mux = bright_q;
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      drive_en <= 1'b0;
      out_q    <= '0;
    end else begin
      drive_en <= rd;
      if (rd) out_q <= rd_mux;
    end
  end

  // The CPU owns the bus whenever it writes, even inside a response cycle.
  assign BUS_DATA = (drive_en && !BUS_WE) ? out_q : 8'hzz;

  // Byte 0 lands in the top byte of LEDS.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      raw[8*(NUM_BYTES-i)-1 -: 8] = data_q[i];
    end
  end

  assign gated = (blink_en && !phase) ? '0 : raw;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      LEDS <= '0;
    end else begin
      LEDS <= invert ? ~lit : lit;
    end
  end

endmodule

// File: tb/tb_led_bus_interface_ctrl.sv
// Self-checking bench for led_bus_interface_ctrl (default build, NUM_BYTES=2, PRESCALE=4).
// Released bus reads as 8'hFF through the tri1 net.
module tb_led_bus_interface_ctrl;

  localparam logic [7:0] BASE = 8'hC0;
  localparam int         NB   = 2;
  localparam int         P    = 4;
  localparam logic [7:0] REL  = 8'hFF;
  localparam logic [7:0] IDLE = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  bus_addr = IDLE;
  logic        bus_we = 1'b0;
  logic        cpu_drive = 1'b0;
  logic [7:0]  cpu_data = 8'h00;
  tri1  [7:0]  bus_data;
  logic [15:0] leds;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] m_data [NB];
  logic [7:0] m_ctrl;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic        chk_led;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  assign bus_data = cpu_drive ? cpu_data : 8'hzz;

  led_bus_interface_ctrl #(.BASE_ADDR(BASE), .NUM_BYTES(NB), .PRESCALE(P)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .BUS_DATA(bus_data),
    .BUS_ADDR(bus_addr),
    .BUS_WE  (bus_we),
    .LEDS    (leds)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release; prescaler ticks land on multiples of P.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] d);
    bus_addr  = addr;
    bus_we    = 1'b1;
    cpu_data  = d;
    cpu_drive = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_drive = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = IDLE;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] d);
    bus_addr  = addr;
    bus_we    = 1'b0;
    cpu_drive = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d = bus_data;
    bus_addr = IDLE;
  endtask

  // Phase after edge x, given a half period of 'half' ticks counted from edge 'base'.
  function automatic logic phase_after(input int x, input int base, input int half, input logic p0);
    int t;
    t = (x / P) - (base / P);
    return p0 ^ logic'((t / half) % 2);
  endfunction

  function automatic logic [15:0] model_leds();
    logic [15:0] raw;
    raw = {m_data[0], m_data[1]};
    return m_ctrl[1] ? ~raw : raw;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == BASE)        return m_data[0];
    if (a == BASE + 8'd1) return m_data[1];
    if (a == BASE + 8'd2) return m_ctrl;
    if (a == BASE + 8'd3) return 8'h01;
    return REL;
  endfunction

  initial begin
    logic [7:0]  rd;
    logic [7:0]  a;
    logic [7:0]  v;
    logic [15:0] exp_led;
    logic        p;
    int          n;
    int          s;
    int          t_next;
    int          e;
    int          op;

    vecs.push_back('{1'b0, 8'hC3, 8'h00, 1'b1, 8'h01, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hC0, 8'h00, 1'b1, 8'h00, 1'b1, 16'h0000});
    vecs.push_back('{1'b1, 8'hC0, 8'hA5, 1'b0, 8'h00, 1'b1, 16'h0000});
    vecs.push_back('{1'b1, 8'hC1, 8'h3C, 1'b0, 8'h00, 1'b1, 16'hA500});
    vecs.push_back('{1'b0, 8'hC0, 8'h00, 1'b1, 8'hA5, 1'b1, 16'hA53C});
    vecs.push_back('{1'b0, 8'hC1, 8'h00, 1'b1, 8'h3C, 1'b1, 16'hA53C});
    vecs.push_back('{1'b1, 8'hC2, 8'h02, 1'b0, 8'h00, 1'b1, 16'hA53C});
    vecs.push_back('{1'b0, 8'hC2, 8'h00, 1'b1, 8'h02, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b1, 8'hC3, 8'hFF, 1'b0, 8'h00, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b0, 8'hC3, 8'h00, 1'b1, 8'h01, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b1, 8'hC4, 8'h77, 1'b0, 8'h00, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b0, 8'hC4, 8'h00, 1'b1, REL,   1'b1, 16'h5AC3});
    vecs.push_back('{1'b1, 8'hBF, 8'h11, 1'b0, 8'h00, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b0, 8'hBF, 8'h00, 1'b1, REL,   1'b1, 16'h5AC3});
    vecs.push_back('{1'b0, 8'hC0, 8'h00, 1'b1, 8'hA5, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b1, 8'hC2, 8'hFE, 1'b0, 8'h00, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b0, 8'hC2, 8'h00, 1'b1, 8'hF2, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b1, 8'hC2, 8'h00, 1'b0, 8'h00, 1'b1, 16'h5AC3});
    vecs.push_back('{1'b0, 8'hC3, 8'h00, 1'b1, 8'h01, 1'b1, 16'hA53C});
    vecs.push_back('{1'b0, 8'hC1, 8'h00, 1'b1, 8'h3C, 1'b1, 16'hA53C});

    // Clock/reset
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_leds", leds, 16'h0000);
    check("reset_bus_released", bus_data, REL);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        bus_read(vecs[i].addr, rd);
        if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      end
      if (vecs[i].chk_led) check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_led);
    end

    // Blink at RATE 0: half period 64 ticks = 256 clocks
    bus_write(BASE + 8'd2, 8'h01);
    n = cyc;
    for (int k = 0; k < 600; k++) begin
      bus_read(BASE + 8'd3, rd);
      e = cyc;
      p = phase_after(e - 1, n, 64, 1'b1);
      check("blink_status", rd, {7'b0, p});
      check("blink_leds", leds, p ? 16'hA53C : 16'h0000);
    end

    // RATE 1 then drop to RATE 0 once the count is past 63: wrap on next tick
    bus_write(BASE + 8'd2, 8'h00);
    bus_write(BASE + 8'd2, 8'h11);
    n = cyc;
    for (int k = 0; k < 400; k++) begin
      bus_read(BASE + 8'd3, rd);
      e = cyc;
      p = phase_after(e - 1, n, 128, 1'b1);
      check("rate1_status", rd, {7'b0, p});
    end
    bus_write(BASE + 8'd2, 8'h01);
    s = cyc;
    t_next = (s / P + 1) * P;
    for (int k = 0; k < 400; k++) begin
      bus_read(BASE + 8'd3, rd);
      e = cyc;
      p = (e - 1 < t_next) ? 1'b1 : phase_after(e - 1, t_next, 64, 1'b0);
      check("rate_drop_status", rd, {7'b0, p});
      check("rate_drop_leds", leds, p ? 16'hA53C : 16'h0000);
    end
    bus_write(BASE + 8'd2, 8'h00);

    // Randomized traffic against the register model
    m_data[0] = 8'hA5;
    m_data[1] = 8'h3C;
    m_ctrl    = 8'h00;
    for (int k = 0; k < 300; k++) begin
      exp_led = model_leds();
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          n = $urandom_range(0, NB - 1);
          v = 8'($urandom_range(0, 255));
          bus_write(BASE + 8'(n), v);
          m_data[n] = v;
        end
        2: begin
          v = 8'($urandom_range(0, 255)) & 8'hFE;
          bus_write(BASE + 8'd2, v);
          m_ctrl = v & 8'hF3;
        end
        3: bus_write(BASE + 8'd3, 8'($urandom_range(0, 255)));
        4: begin
          if ($urandom_range(0, 1) == 0) begin
            a = BASE + 8'd4;
          end else begin
            do a = 8'($urandom_range(0, 255)); while (a >= BASE && a <= BASE + 8'd3);
          end
          bus_write(a, 8'($urandom_range(0, 255)));
        end
        default: begin
          a = BASE - 8'd1 + 8'($urandom_range(0, 5));
          exp_q.push_back(model_read(a));
          bus_read(a, rd);
          check($sformatf("rand_rd_%02h", a), rd, exp_q.pop_front());
        end
      endcase
      check("rand_leds", leds, exp_led);
    end

    // Asynchronous reset in the middle of a read response
    bus_read(BASE, rd);
    check("pre_reset_rd", rd, m_data[0]);
    #2 rst_n = 1'b0;
    #1;
    check("midread_reset_bus", bus_data, REL);
    check("midread_reset_leds", leds, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(BASE, rd);
    check("post_reset_data0", rd, 8'h00);
    bus_read(BASE + 8'd1, rd);
    check("post_reset_data1", rd, 8'h00);
    bus_read(BASE + 8'd2, rd);
    check("post_reset_ctrl", rd, 8'h00);
    bus_read(BASE + 8'd3, rd);
    check("post_reset_status", rd, 8'h01);
    check("post_reset_leds", leds, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
